// File: rtl/dec_rx_fsm.sv
// Receive-sequence controller for the 64b/66b PCS decode path: classifies decoded blocks,
// runs the C/S/D/T/E receive state machine with one-block lookahead and substitutes error blocks.
module dec_rx_fsm #(
    parameter int IS_40G      = 1,
    parameter int DATA_W      = 64,
    parameter int KEEP_W      = DATA_W / 8,
    parameter int LANE0_CNT_N = (IS_40G != 0) ? 1 : 2,
    parameter int ERR_CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   nreset,
    input  logic                   valid_i,
    input  logic                   block_lock_i,
    input  logic                   hi_ber_i,
    input  logic [1:0]             head_i,
    input  logic                   ctrl_v_i,
    input  logic                   idle_v_i,
    input  logic                   term_v_i,
    input  logic                   err_v_i,
    input  logic                   ord_v_i,
    input  logic [LANE0_CNT_N-1:0] start_v_i,
    input  logic [DATA_W-1:0]      data_i,
    input  logic [KEEP_W-1:0]      keep_i,
    output logic                   valid_o,
    output logic                   ctrl_v_o,
    output logic                   idle_v_o,
    output logic                   term_v_o,
    output logic                   err_v_o,
    output logic                   ord_v_o,
    output logic [LANE0_CNT_N-1:0] start_v_o,
    output logic [DATA_W-1:0]      data_o,
    output logic [KEEP_W-1:0]      keep_o,
    output logic                   lf_v_o,
    input  logic                   err_cnt_clr_i,
    output logic [ERR_CNT_W-1:0]   err_cnt_o
);

    typedef enum logic [2:0] {
        BLK_C = 3'd0,
        BLK_S = 3'd1,
        BLK_D = 3'd2,
        BLK_T = 3'd3,
        BLK_E = 3'd4
    } blk_type_t;

    typedef enum logic [2:0] {
        ST_INIT = 3'd0,
        ST_C    = 3'd1,
        ST_D    = 3'd2,
        ST_T    = 3'd3,
        ST_E    = 3'd4
    } state_t;

    typedef struct packed {
        logic                   ctrl_v;
        logic                   idle_v;
        logic                   term_v;
        logic                   err_v;
        logic                   ord_v;
        logic [LANE0_CNT_N-1:0] start_v;
        logic [KEEP_W-1:0]      keep;
        logic [DATA_W-1:0]      data;
    } blk_t;

    localparam logic [1:0]           HEAD_DATA   = 2'b01;
    localparam logic [1:0]           HEAD_CTRL   = 2'b10;
    localparam logic [DATA_W-1:0]    ERR_DATA    = {KEEP_W{8'hFE}};
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = {ERR_CNT_W{1'b1}};

    // Block type of one decoded block; in 40G mode only lane 0 can carry a start.
    function automatic blk_type_t classify(input logic [1:0] head, input blk_t blk);
        blk_type_t typ;
        logic      start_any;
        logic      is_ctrl;
        start_any = (IS_40G != 0) ? blk.start_v[0] : (|blk.start_v);
        is_ctrl   = (head == HEAD_CTRL) && blk.ctrl_v;
        if (head == HEAD_DATA) begin
            typ = BLK_D;
        end else if (is_ctrl && start_any) begin
            typ = BLK_S;
        end else if (is_ctrl && blk.term_v) begin
            typ = BLK_T;
        end else if (is_ctrl && (blk.idle_v || blk.ord_v) && !blk.err_v) begin
            typ = BLK_C;
        end else begin
            typ = BLK_E;
        end
        return typ;
    endfunction

    function automatic logic legal_after_t(input blk_type_t nxt);
        return (nxt == BLK_S) || (nxt == BLK_C);
    endfunction

    // Receive state machine step, judging the held block with the following block's type.
    function automatic state_t fsm_next(input state_t st, input blk_type_t held, input blk_type_t nxt);
        state_t ns;
        case (st)
            ST_INIT, ST_C, ST_T: begin
                case (held)
                    BLK_C:   ns = ST_C;
                    BLK_S:   ns = ST_D;
                    default: ns = ST_E;
                endcase
            end
            ST_D: begin
                case (held)
                    BLK_D:   ns = ST_D;
                    BLK_T:   ns = legal_after_t(nxt) ? ST_T : ST_E;
                    default: ns = ST_E;
                endcase
            end
            ST_E: begin
                case (held)
                    BLK_C:   ns = ST_C;
                    BLK_D:   ns = ST_D;
                    BLK_T:   ns = legal_after_t(nxt) ? ST_T : ST_E;
                    default: ns = ST_E;
                endcase
            end
            default: ns = ST_E;
        endcase
        return ns;
    endfunction

    state_t                 state_r;
    state_t                 state_nxt_s;
    state_t                 judge_s;
    logic                   hold_v_r;
    logic                   hold_v_nxt_s;
    blk_type_t              hold_type_r;
    blk_type_t              hold_type_nxt_s;
    blk_t                   hold_blk_r;
    blk_t                   hold_blk_nxt_s;
    blk_t                   blk_in_s;
    blk_type_t              type_in_s;
    blk_t                   err_blk_s;
    logic                   out_v_r;
    logic                   out_v_nxt_s;
    blk_t                   out_blk_r;
    blk_t                   out_blk_nxt_s;
    logic                   lf_r;
    logic                   link_down_s;
    logic                   err_inc_s;
    logic [ERR_CNT_W-1:0]   err_cnt_r;
    logic [ERR_CNT_W-1:0]   err_cnt_nxt_s;

    assign link_down_s = !block_lock_i || hi_ber_i;

    // Pack the incoming block and the substitute error block.
    always_comb begin
        blk_in_s.ctrl_v   = ctrl_v_i;
        blk_in_s.idle_v   = idle_v_i;
        blk_in_s.term_v   = term_v_i;
        blk_in_s.err_v    = err_v_i;
        blk_in_s.ord_v    = ord_v_i;
        blk_in_s.start_v  = start_v_i;
        blk_in_s.keep     = keep_i;
        blk_in_s.data     = data_i;
        err_blk_s.ctrl_v  = 1'b1;
        err_blk_s.idle_v  = 1'b0;
        err_blk_s.term_v  = 1'b0;
        err_blk_s.err_v   = 1'b1;
        err_blk_s.ord_v   = 1'b0;
        err_blk_s.start_v = {LANE0_CNT_N{1'b0}};
        err_blk_s.keep    = {KEEP_W{1'b0}};
        err_blk_s.data    = ERR_DATA;
    end

    assign type_in_s = classify(head_i, blk_in_s);
    assign judge_s   = fsm_next(state_r, hold_type_r, type_in_s);

    // Next state, lookahead register and output block selection.
    always_comb begin
        state_nxt_s     = state_r;
        hold_v_nxt_s    = hold_v_r;
        hold_type_nxt_s = hold_type_r;
        hold_blk_nxt_s  = hold_blk_r;
        out_v_nxt_s     = 1'b0;
        out_blk_nxt_s   = out_blk_r;
        err_inc_s       = 1'b0;
        if (link_down_s) begin
            // The held block is dropped silently: it is never judged, so never counted.
            state_nxt_s  = ST_INIT;
            hold_v_nxt_s = 1'b0;
        end else if (valid_i) begin
            hold_v_nxt_s    = 1'b1;
            hold_type_nxt_s = type_in_s;
            hold_blk_nxt_s  = blk_in_s;
            if (hold_v_r) begin
                state_nxt_s = judge_s;
                out_v_nxt_s = 1'b1;
                if (judge_s == ST_E) begin
                    out_blk_nxt_s = err_blk_s;
                    err_inc_s     = 1'b1;
                end else begin
                    out_blk_nxt_s = hold_blk_r;
                end
            end else begin
                state_nxt_s = state_r;
            end
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Saturating error counter; a clear overrides a simultaneous increment.
    always_comb begin
        err_cnt_nxt_s = err_cnt_r;
        if (err_cnt_clr_i) begin
            err_cnt_nxt_s = {ERR_CNT_W{1'b0}};
        end else if (err_inc_s && (err_cnt_r != ERR_CNT_MAX)) begin
            err_cnt_nxt_s = err_cnt_r + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            err_cnt_nxt_s = err_cnt_r;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_r <= ST_INIT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Lookahead register, registered outputs, local fault and error counter.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            hold_v_r    <= 1'b0;
            hold_type_r <= BLK_E;
            hold_blk_r  <= {$bits(blk_t){1'b0}};
            out_v_r     <= 1'b0;
            out_blk_r   <= {$bits(blk_t){1'b0}};
            lf_r        <= 1'b1;
            err_cnt_r   <= {ERR_CNT_W{1'b0}};
        end else begin
            hold_v_r    <= hold_v_nxt_s;
            hold_type_r <= hold_type_nxt_s;
            hold_blk_r  <= hold_blk_nxt_s;
            out_v_r     <= out_v_nxt_s;
            out_blk_r   <= out_blk_nxt_s;
            lf_r        <= link_down_s;
            err_cnt_r   <= err_cnt_nxt_s;
        end
    end

    assign valid_o   = out_v_r;
    assign ctrl_v_o  = out_blk_r.ctrl_v;
    assign idle_v_o  = out_blk_r.idle_v;
    assign term_v_o  = out_blk_r.term_v;
    assign err_v_o   = out_blk_r.err_v;
    assign ord_v_o   = out_blk_r.ord_v;
    assign start_v_o = out_blk_r.start_v;
    assign data_o    = out_blk_r.data;
    assign keep_o    = out_blk_r.keep;
    assign lf_v_o    = lf_r;
    assign err_cnt_o = err_cnt_r;

endmodule
